cpf_frame_tx: RTL and testbench

Parametrised CP_F frame transmitter. It accepts one complete frame payload (status, control, address, data bytes) per valid/ready handshake and serialises it as a symbol stream: SOF K-char, payload bytes, computed CRC8, then EOF K-char. Between frames it fills the line with idle commas. It sits directly upstream of the 8b10b encoder: its byte/K-flag/enable outputs drive the encoder's data, KI and ena inputs.

---
 rtl/cpf_pkg.sv | 24 ++
 rtl/cpf_frame_tx_crc8.sv | 20 ++
 rtl/cpf_frame_tx.sv | 146 ++++++++++++++
 tb/tb_cpf_frame_tx.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpf_pkg.sv
// Shared symbols, CRC defaults and FSM state type for the CP_F frame transmitter.
// The GAP state only exists when CPF_FRAME_TX_GAP_EN is defined.
package cpf_pkg;

  localparam logic [7:0] K28_5_IDLE = 8'hBC;
  localparam logic [7:0] K28_1_SOF  = 8'h3C;
  localparam logic [7:0] K29_7_EOF  = 8'hFD;

  localparam logic [7:0] DEFAULT_CRC_POLY = 8'h07;
  localparam logic [7:0] DEFAULT_CRC_INIT = 8'hFF;

  // Each state names the symbol currently driven on the outputs.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_PAYLOAD,
    ST_CRC,
    ST_EOF
`ifdef CPF_FRAME_TX_GAP_EN
    , ST_GAP
`endif
  } state_t;

endpackage

// File: rtl/cpf_frame_tx_crc8.sv
// crc8_byte_step: one byte of MSB-first, non-reflected CRC8, purely combinational.
module crc8_byte_step #(
  parameter logic [7:0] POLY = 8'h07
) (
  input  logic [7:0] crc_in,
  input  logic [7:0] data_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      c = {c[6:0], 1'b0} ^ ((c[7] ^ data_in[i]) ? POLY : 8'h00);
    end
    crc_out = c;
  end

endmodule

// File: rtl/cpf_frame_tx.sv
// cpf_frame_tx: serialises SOF, payload, CRC8 and EOF symbols for the 8b10b encoder.
// Define CPF_FRAME_TX_GAP_EN to force GAP_SYMBOLS idle commas after every EOF.
module cpf_frame_tx
  import cpf_pkg::*;
#(
  parameter int         PAYLOAD_BYTES = 4,
  parameter logic [7:0] CRC_POLY      = DEFAULT_CRC_POLY,
  parameter logic [7:0] CRC_INIT      = DEFAULT_CRC_INIT,
  parameter int         GAP_SYMBOLS   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sym_en,
  input  logic                       frame_valid,
  output logic                       frame_ready,
  input  logic [8*PAYLOAD_BYTES-1:0] frame_data,
  output logic [7:0]                 tx_byte,
  output logic                       tx_k,
  output logic                       tx_ena,
  output logic                       frame_done
);

  localparam int             CW   = $clog2(PAYLOAD_BYTES + 1);
  localparam logic [CW-1:0]  LAST = CW'(PAYLOAD_BYTES - 1);

  state_t                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [7:0]                 crc_q, crc_d, crc_step;
  logic [8*PAYLOAD_BYTES-1:0] shift_q, shift_d;
  logic [7:0]                 byte_d;
  logic                       k_d, done_d, accept;
  logic [7:0]                 head;

`ifdef CPF_FRAME_TX_GAP_EN
  localparam int            GW       = (GAP_SYMBOLS > 1) ? $clog2(GAP_SYMBOLS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_SYMBOLS - 1);
  logic [GW-1:0]            gap_q, gap_d;

  assign frame_ready = sym_en & ~reset & (state_q == ST_IDLE);
`else
  assign frame_ready = sym_en & ~reset & ((state_q == ST_IDLE) | (state_q == ST_EOF));
`endif

  assign accept = frame_valid & frame_ready;
  assign head   = shift_q[8*PAYLOAD_BYTES-1 -: 8];

  crc8_byte_step #(.POLY(CRC_POLY)) u_crc (
    .crc_in  (crc_q),
    .data_in (head),
    .crc_out (crc_step)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    crc_d   = crc_q;
    shift_d = shift_q;
    byte_d  = K28_5_IDLE;
    k_d     = 1'b1;
    done_d  = 1'b0;
`ifdef CPF_FRAME_TX_GAP_EN
    gap_d   = gap_q;
`endif
    case (state_q)
      ST_SOF: begin
        state_d = ST_PAYLOAD;
        byte_d  = head;
        k_d     = 1'b0;
        crc_d   = crc_step;
        shift_d = shift_q << 8;
      end
      // cnt_q is the index of the payload byte currently on the outputs.
      ST_PAYLOAD: begin
        k_d = 1'b0;
        if (cnt_q == LAST) begin
          state_d = ST_CRC;
          byte_d  = crc_q;
        end else begin
          byte_d  = head;
          crc_d   = crc_step;
          shift_d = shift_q << 8;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_CRC: begin
        state_d = ST_EOF;
        byte_d  = K29_7_EOF;
        done_d  = 1'b1;
      end
`ifdef CPF_FRAME_TX_GAP_EN
      ST_EOF: begin
        state_d = (GAP_SYMBOLS == 0) ? ST_IDLE : ST_GAP;
        gap_d   = '0;
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) state_d = ST_IDLE;
        else                   gap_d   = gap_q + GW'(1);
      end
`else
      ST_EOF:  state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase

    // Acceptance is only possible in IDLE/EOF, so it overrides those paths.
    if (accept) begin
      state_d = ST_SOF;
      byte_d  = K28_1_SOF;
      k_d     = 1'b1;
      shift_d = frame_data;
      crc_d   = CRC_INIT;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      crc_q      <= CRC_INIT;
      shift_q    <= '0;
      tx_byte    <= K28_5_IDLE;
      tx_k       <= 1'b1;
      tx_ena     <= 1'b0;
      frame_done <= 1'b0;
`ifdef CPF_FRAME_TX_GAP_EN
      gap_q      <= '0;
`endif
    end else begin
      tx_ena <= sym_en;
      if (sym_en) begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        crc_q      <= crc_d;
        shift_q    <= shift_d;
        tx_byte    <= byte_d;
        tx_k       <= k_d;
        frame_done <= done_d;
`ifdef CPF_FRAME_TX_GAP_EN
        gap_q      <= gap_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cpf_frame_tx.sv
// Self-checking bench for cpf_frame_tx: random frames compared to a symbol-stream model.
// Honours CPF_FRAME_TX_GAP_EN to expect GAP_SYMBOLS+1 idles between held-valid frames.
module tb_cpf_frame_tx;

  localparam int P   = 4;
  localparam int GAP = 2;
`ifdef CPF_FRAME_TX_GAP_EN
  localparam int IDLES_BETWEEN = GAP + 1;
`else
  localparam int IDLES_BETWEEN = 0;
`endif

  // Stream element: {frame_done, tx_k, tx_byte}
  typedef logic [9:0] sym_q_t[$];

  logic           clk = 1'b0;
  logic           reset, sym_en, frame_valid, frame_ready;
  logic [8*P-1:0] frame_data;
  logic [7:0]     tx_byte;
  logic           tx_k, tx_ena, frame_done;

  int     vectors = 0;
  int     miscompares = 0;
  sym_q_t obs_q;

  always #5 clk = ~clk;

  cpf_frame_tx #(
    .PAYLOAD_BYTES (P),
    .CRC_POLY      (8'h07),
    .CRC_INIT      (8'hFF),
    .GAP_SYMBOLS   (GAP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sym_en      (sym_en),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data),
    .tx_byte     (tx_byte),
    .tx_k        (tx_k),
    .tx_ena      (tx_ena),
    .frame_done  (frame_done)
  );

  // Bit-serial CRC over the whole payload, straight from the polynomial definition.
  function automatic logic [7:0] model_crc(input logic [8*P-1:0] d);
    logic [7:0] c;
    c = 8'hFF;
    for (int b = 8*P-1; b >= 0; b--)
      c = {c[6:0], 1'b0} ^ ((c[7] ^ d[b]) ? 8'h07 : 8'h00);
    return c;
  endfunction

  function automatic sym_q_t model_frame(input logic [8*P-1:0] d);
    sym_q_t q;
    q.push_back({2'b01, 8'h3C});
    for (int i = P-1; i >= 0; i--) q.push_back({2'b00, d[8*i +: 8]});
    q.push_back({2'b00, model_crc(d)});
    q.push_back({2'b11, 8'hFD});
    return q;
  endfunction

  // Offers one frame, then records every enabled symbol through EOF into obs_q.
  task automatic run_frame(input logic [8*P-1:0] data, input bit toggle, output int hold_err);
    int         n;
    bit         acc, done;
    logic [8:0] prev;
    logic       last_en;
    obs_q.delete();
    hold_err    = 0;
    acc         = 1'b0;
    n           = 0;
    frame_data  = data;
    frame_valid = 1'b1;
    while (!acc && n < 60) begin
      sym_en = toggle ? !sym_en : 1'b1;
      #1;
      acc = frame_ready;
      @(posedge clk); #1;
      n++;
    end
    frame_valid = 1'b0;
    frame_data  = $urandom;
    if (!acc) return;
    done    = 1'b0;
    n       = 0;
    prev    = {tx_k, tx_byte};
    last_en = 1'b1;
    while (!done && n < 100) begin
      if (tx_ena !== last_en) hold_err++;
      if (tx_ena) begin
        obs_q.push_back({frame_done, tx_k, tx_byte});
        done = (tx_k === 1'b1) && (tx_byte === 8'hFD);
      end else if ({tx_k, tx_byte} !== prev) begin
        hold_err++;
      end
      prev = {tx_k, tx_byte};
      if (!done) begin
        sym_en  = toggle ? !sym_en : 1'b1;
        last_en = sym_en;
        @(posedge clk); #1;
        n++;
      end
    end
  endtask

  task automatic drain(input int cycles);
    frame_valid = 1'b0;
    sym_en      = 1'b1;
    repeat (cycles) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    reset = 1'b1; sym_en = 1'b0; frame_valid = 1'b0; frame_data = '0;
    repeat (3) begin @(posedge clk); #1; end
    vectors++;
    if ({tx_ena, frame_done, tx_k, tx_byte} !== {2'b00, 1'b1, 8'hBC} || frame_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_values got ena=%b done=%b k=%b byte=%h ready=%b want 0 0 1 bc 0",
               tx_ena, frame_done, tx_k, tx_byte, frame_ready);
    end
    reset = 1'b0; sym_en = 1'b1;
    #1;
    vectors++;
    if (frame_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_reset got %b want 1", frame_ready);
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({tx_k, tx_byte} !== 9'h1BC || tx_ena !== 1'b1 || frame_ready !== 1'b1 || frame_done !== 1'b0) begin
        miscompares++;
        $display("[TB] FAIL idle_fill[%0d] got k=%b byte=%h ena=%b ready=%b done=%b want 1 bc 1 1 0",
                 i, tx_k, tx_byte, tx_ena, frame_ready, frame_done);
      end
    end
  endtask

  task automatic test_zero_frame;
    sym_q_t exp;
    int     h;
    exp = '{10'h13C, 10'h000, 10'h000, 10'h000, 10'h000, 10'h0D1, 10'h3FD};
    run_frame('0, 1'b0, h);
    vectors++;
    if (obs_q.size() != exp.size()) begin
      miscompares++;
      $display("[TB] FAIL zero_len got %0d want %0d", obs_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp[i]) begin
          miscompares++;
          $display("[TB] FAIL zero_sym[%0d] got %h want %h", i, obs_q[i], exp[i]);
        end
      end
    end
  endtask

  task automatic test_random_frames;
    sym_q_t         exp;
    logic [8*P-1:0] d;
    int             h;
    for (int f = 0; f < 6; f++) begin
      d   = $urandom;
      exp = model_frame(d);
      run_frame(d, 1'b0, h);
      vectors++;
      if (obs_q.size() != exp.size()) begin
        miscompares++;
        $display("[TB] FAIL rand_len[%0d] got %0d want %0d", f, obs_q.size(), exp.size());
      end else begin
        for (int i = 0; i < exp.size(); i++) begin
          vectors++;
          if (obs_q[i] !== exp[i]) begin
            miscompares++;
            $display("[TB] FAIL rand_sym[%0d][%0d] data=%h got %h want %h", f, i, d, obs_q[i], exp[i]);
          end
        end
      end
    end
  endtask

  task automatic test_sym_en_toggle;
    sym_q_t         exp;
    logic [8*P-1:0] d;
    int             h;
    for (int f = 0; f < 3; f++) begin
      d   = $urandom;
      exp = model_frame(d);
      run_frame(d, 1'b1, h);
      vectors++;
      if (h != 0) begin
        miscompares++;
        $display("[TB] FAIL toggle_hold[%0d] got %0d hold/ena errors want 0", f, h);
      end
      vectors++;
      if (obs_q.size() != exp.size()) begin
        miscompares++;
        $display("[TB] FAIL toggle_len[%0d] got %0d want %0d", f, obs_q.size(), exp.size());
      end else begin
        for (int i = 0; i < exp.size(); i++) begin
          vectors++;
          if (obs_q[i] !== exp[i]) begin
            miscompares++;
            $display("[TB] FAIL toggle_sym[%0d][%0d] got %h want %h", f, i, obs_q[i], exp[i]);
          end
        end
      end
    end
    drain(8);
  endtask

  task automatic test_back_to_back;
    sym_q_t         exp, f2;
    logic [8*P-1:0] d;
    drain(8);
    d   = $urandom;
    exp = model_frame(d);
    for (int i = 0; i < IDLES_BETWEEN; i++) exp.push_back(10'h1BC);
    f2  = model_frame(d);
    foreach (f2[i]) exp.push_back(f2[i]);
    obs_q.delete();
    frame_data  = d;
    frame_valid = 1'b1;
    sym_en      = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      obs_q.push_back({frame_done, tx_k, tx_byte});
    end
    for (int i = 0; i < exp.size(); i++) begin
      vectors++;
      if (obs_q[i] !== exp[i]) begin
        miscompares++;
        $display("[TB] FAIL b2b_sym[%0d] got %h want %h", i, obs_q[i], exp[i]);
      end
    end
    drain(20);
  endtask

  task automatic test_reset_abort;
    sym_q_t         exp;
    logic [8*P-1:0] d;
    int             h;
    drain(8);
    d = $urandom;
    frame_data = d; frame_valid = 1'b1; sym_en = 1'b1;
    @(posedge clk); #1;
    frame_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    vectors++;
    if ({tx_k, tx_byte} !== {1'b0, d[8*P-9 -: 8]}) begin
      miscompares++;
      $display("[TB] FAIL abort_second_byte got k=%b byte=%h want 0 %h", tx_k, tx_byte, d[8*P-9 -: 8]);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vectors++;
    if ({tx_ena, frame_done, tx_k, tx_byte} !== {2'b00, 1'b1, 8'hBC}) begin
      miscompares++;
      $display("[TB] FAIL abort_reset got ena=%b done=%b k=%b byte=%h want 0 0 1 bc",
               tx_ena, frame_done, tx_k, tx_byte);
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      vectors++;
      if ({frame_done, tx_k, tx_byte} !== 10'h1BC) begin
        miscompares++;
        $display("[TB] FAIL abort_idle[%0d] got %h want 1bc", i, {frame_done, tx_k, tx_byte});
      end
    end
    d   = $urandom;
    exp = model_frame(d);
    run_frame(d, 1'b0, h);
    vectors++;
    if (obs_q.size() != exp.size()) begin
      miscompares++;
      $display("[TB] FAIL abort_next_len got %0d want %0d", obs_q.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        vectors++;
        if (obs_q[i] !== exp[i]) begin
          miscompares++;
          $display("[TB] FAIL abort_next_sym[%0d] got %h want %h", i, obs_q[i], exp[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_random_frames();
    test_sym_en_toggle();
    test_back_to_back();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
